// File: rtl/cpu_pkg.sv
// Shared CPU definitions: implemented opcodes and the program-loader state encoding.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned HDR_W    = 16;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR_HI,
    LD_HDR_LO,
    LD_DATA,
    LD_WRITE,
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/opcode_legal.sv
// Flags whether a 6-bit opcode is one the CPU controller implements.
module opcode_legal
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal_c
);

  always_comb begin
    legal_c = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: legal_c = 1'b1;
      default:                                    legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles big-endian words from a host link and
// writes them into instruction memory from word 0, holding the CPU meanwhile.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                in_ready,
  output logic                im_we,
  output logic [ADDR_W-1:0]   im_addr,
  output logic [WORD_W-1:0]   im_wdata,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err_len,
  output logic                err_illegal,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned CAPACITY = 1 << ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  loader_state_t     state;
  loader_state_t     state_nxt_c;
  logic [HDR_W-1:0]  n_words;
  logic [1:0]        byte_idx;

  logic              xfer_c;
  logic [HDR_W-1:0]  hdr_full_c;
  logic              hdr_too_big_c;
  logic              last_word_c;
  logic              op_legal_c;

  assign xfer_c        = in_valid && in_ready;
  assign hdr_full_c    = {n_words[HDR_W-1:BYTE_W], in_data};
  assign hdr_too_big_c = 32'(hdr_full_c) > CAPACITY;
  // word_count has not yet been bumped while in WRITE, hence the +1
  assign last_word_c   = (32'(word_count) + 32'd1) == 32'(n_words);

  opcode_legal u_opcode_legal (
    .opcode  (im_wdata[WORD_W-1 -: OPCODE_W]),
    .legal_c (op_legal_c)
  );

  // Next-state decode
  always_comb begin
    state_nxt_c = state;
    case (state)
      LD_IDLE, LD_DONE: begin
        if (start) state_nxt_c = LD_HDR_HI;
      end
      LD_HDR_HI: begin
        if (xfer_c) state_nxt_c = LD_HDR_LO;
      end
      LD_HDR_LO: begin
        if (xfer_c) begin
          if (hdr_full_c == '0 || hdr_too_big_c) state_nxt_c = LD_DONE;
          else                                   state_nxt_c = LD_DATA;
        end
      end
      LD_DATA: begin
        if (xfer_c && byte_idx == 2'd3) state_nxt_c = LD_WRITE;
      end
      LD_WRITE: begin
        state_nxt_c = last_word_c ? LD_DONE : LD_DATA;
      end
      default: state_nxt_c = LD_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LD_IDLE;
      n_words     <= '0;
      byte_idx    <= '0;
      in_ready    <= 1'b0;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      cpu_hold    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_len     <= 1'b0;
      err_illegal <= 1'b0;
      word_count  <= '0;
    end else begin
      state    <= state_nxt_c;
      in_ready <= (state_nxt_c == LD_HDR_HI) || (state_nxt_c == LD_HDR_LO) ||
                  (state_nxt_c == LD_DATA);
      im_we    <= (state_nxt_c == LD_WRITE);
      cpu_hold <= (state_nxt_c != LD_IDLE) && (state_nxt_c != LD_DONE);
      busy     <= (state_nxt_c != LD_IDLE) && (state_nxt_c != LD_DONE);
      done     <= (state_nxt_c == LD_DONE);

      case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            err_len     <= 1'b0;
            err_illegal <= 1'b0;
            word_count  <= '0;
            im_addr     <= '0;
            byte_idx    <= '0;
            n_words     <= '0;
          end
        end
        LD_HDR_HI: begin
          if (xfer_c) n_words[HDR_W-1:BYTE_W] <= in_data;
        end
        LD_HDR_LO: begin
          if (xfer_c) begin
            n_words[BYTE_W-1:0] <= in_data;
            byte_idx            <= '0;
            if (hdr_too_big_c) err_len <= 1'b1;
          end
        end
        LD_DATA: begin
          if (xfer_c) begin
            im_wdata <= {im_wdata[WORD_W-BYTE_W-1:0], in_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        LD_WRITE: begin
          word_count <= word_count + CNT_W'(1);
          im_addr    <= im_addr + ADDR_W'(1);
          // Illegal words are still written; the flag only reports them
          if (!op_legal_c) err_illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
